// File: rtl/imem_axi_rd_slave.sv
// imem_axi_rd_slave
// Instruction-memory slave for an instruction-fetch master. It serves AXI-style
// read bursts out of a DEPTH x 32-bit on-chip memory. The memory is filled
// through a simple image-load write port.
//
// Ports
//   clk, rst_n                         : clock, asynchronous active-low reset
//   arvalid/arready, araddr, arlen,
//   arsize, arburst, arcache           : read-address channel (arcache ignored)
//   rvalid/rready, rdata, rresp, rlast : read-data channel
//   load_we, load_addr, load_wdata     : image-load word write (byte address)
//   busy                               : high whenever a burst is in progress
//
// Each beat takes two cycles: a FETCH cycle registers the memory word, and then
// the DATA cycle(s) present the beat until the master accepts it.
module imem_axi_rd_slave #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        arvalid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [3:0]  arcache,
  output logic        arready,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  input  logic        load_we,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_wdata,
  output logic        busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  // A byte address names a real word only if it is word aligned and below DEPTH*4.
  function automatic logic word_ok(input logic [31:0] a);
    word_ok = (a[1:0] == 2'b00) && (a[31:AW+2] == {(30-AW){1'b0}});
  endfunction

  // A beat fails on an unsupported size, a WRAP/reserved burst type, or a bad address.
  function automatic logic beat_err(input logic [31:0] a, input logic [2:0] sz,
                                    input logic [1:0] bt);
    beat_err = (sz != 3'd2) || bt[1] || !word_ok(a);
  endfunction

  logic [31:0] mem [0:DEPTH-1];

  logic [1:0]  state_r;
  logic [1:0]  state_nxt_s;
  logic [31:0] addr_r;
  logic [31:0] addr_nxt_s;
  logic [7:0]  len_r;
  logic [2:0]  size_r;
  logic [1:0]  burst_r;
  logic [7:0]  beat_r;
  logic        arready_r;
  logic        rvalid_r;
  logic [31:0] rdata_r;
  logic [1:0]  rresp_r;
  logic        rlast_r;
  logic        busy_r;
  logic [31:0] rd_word_s;
  logic        rd_err_s;
  logic        ar_hs_s;
  logic        unused_arcache_s;

  assign unused_arcache_s = ^arcache;

  assign ar_hs_s   = arvalid && arready_r;
  assign rd_word_s = mem[addr_r[AW+1:2]];
  assign rd_err_s  = beat_err(addr_r, size_r, burst_r);

  // Next-state decode and the address of the following beat.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (ar_hs_s) begin
          state_nxt_s = FETCH;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      FETCH: state_nxt_s = DATA;
      DATA: begin
        if (rready) begin
          state_nxt_s = rlast_r ? IDLE : FETCH;
        end else begin
          state_nxt_s = DATA;
        end
      end
      default: state_nxt_s = IDLE;
    endcase

    // FIXED (and the error-only burst types) keep the address; INCR wraps
    // naturally at the 32-bit boundary.
    if (burst_r == BURST_INCR) begin
      addr_nxt_s = addr_r + 32'd4;
    end else begin
      addr_nxt_s = addr_r;
    end
  end

  // Burst control, address/beat tracking and the registered read channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      addr_r    <= 32'd0;
      len_r     <= 8'd0;
      size_r    <= 3'd0;
      burst_r   <= 2'd0;
      beat_r    <= 8'd0;
      arready_r <= 1'b0;
      rvalid_r  <= 1'b0;
      rdata_r   <= 32'd0;
      rresp_r   <= RESP_OKAY;
      rlast_r   <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      // arready and busy are decoded from the next state so both are clean flops.
      arready_r <= (state_nxt_s == IDLE);
      busy_r    <= (state_nxt_s != IDLE);
      case (state_r)
        IDLE: begin
          if (ar_hs_s) begin
            addr_r  <= araddr;
            len_r   <= arlen;
            size_r  <= arsize;
            burst_r <= arburst;
            beat_r  <= 8'd0;
          end
        end
        FETCH: begin
          rvalid_r <= 1'b1;
          rlast_r  <= (beat_r == len_r);
          if (rd_err_s) begin
            rdata_r <= 32'd0;
            rresp_r <= RESP_SLVERR;
          end else begin
            rdata_r <= rd_word_s;
            rresp_r <= RESP_OKAY;
          end
        end
        DATA: begin
          if (rready) begin
            rvalid_r <= 1'b0;
            rlast_r  <= 1'b0;
            if (!rlast_r) begin
              beat_r <= beat_r + 8'd1;
              addr_r <= addr_nxt_s;
            end
          end
        end
        default: begin
          rvalid_r <= 1'b0;
          rlast_r  <= 1'b0;
        end
      endcase
    end
  end

  // Image-load port. It is independent of the FSM and of reset, so the image
  // survives a reset. A read of the same word in the same cycle sees old data.
  always_ff @(posedge clk) begin
    if (load_we && word_ok(load_addr)) begin
      mem[load_addr[AW+1:2]] <= load_wdata;
    end
  end

  assign arready = arready_r;
  assign rvalid  = rvalid_r;
  assign rdata   = rdata_r;
  assign rresp   = rresp_r;
  assign rlast   = rlast_r;
  assign busy    = busy_r;

endmodule

// File: tb/tb_imem_axi_rd_slave.sv
// Testbench for imem_axi_rd_slave. A transaction-level model predicts every
// beat of a burst when its address is accepted. A per-cycle compare process
// then checks the handshake outputs and beat contents against that model.
module tb_imem_axi_rd_slave;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        arvalid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [3:0]  arcache;
  logic        arready;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        load_we;
  logic [31:0] load_addr;
  logic [31:0] load_wdata;
  logic        busy;

  imem_axi_rd_slave #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .arvalid(arvalid), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst), .arcache(arcache), .arready(arready),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .load_we(load_we), .load_addr(load_addr), .load_wdata(load_wdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  int rr_mode = 0;   // 0: rready=1, 1: random, 2: rready=0

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic word_ok(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a < 32'(DEPTH * 4));
  endfunction

  // ---------------- behavioural model ----------------
  logic [31:0] model_mem [DEPTH];
  logic [31:0] m_data [256];
  logic [1:0]  m_resp [256];
  logic        m_ready, m_valid, m_idle, m_cd;
  int          m_head, m_n;
  logic [31:0] ba;
  logic        bad;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ready <= 1'b0; m_valid <= 1'b0; m_idle <= 1'b1; m_cd <= 1'b0; m_head <= 0; m_n <= 0;
    end else begin
      if (m_idle) begin
        if (m_ready && arvalid) begin
          // The whole burst is known at acceptance: beat i lives at araddr+4i (INCR)
          // or araddr (FIXED), and it fails on any illegal attribute or address.
          for (int i = 0; i <= int'(arlen); i++) begin
            ba  = (arburst == 2'b01) ? araddr + 32'(4 * i) : araddr;
            bad = (arsize != 3'd2) || !(arburst inside {2'b00, 2'b01}) || !word_ok(ba);
            m_data[i] <= bad ? 32'd0 : model_mem[ba[AW+1:2]];
            m_resp[i] <= bad ? 2'b10 : 2'b00;
          end
          m_n <= int'(arlen); m_head <= 0; m_idle <= 1'b0; m_ready <= 1'b0; m_cd <= 1'b1;
        end else begin
          m_ready <= 1'b1;
        end
      end else if (m_cd) begin
        m_valid <= 1'b1; m_cd <= 1'b0;
      end else if (m_valid && rready) begin
        m_valid <= 1'b0;
        if (m_head == m_n) begin
          m_idle <= 1'b1; m_ready <= 1'b1;
        end else begin
          m_head <= m_head + 1; m_cd <= 1'b1;
        end
      end
      if (load_we && word_ok(load_addr)) model_mem[load_addr[AW+1:2]] <= load_wdata;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- per-cycle compare + observation ----------------
  logic [31:0] obs_data [16];
  logic [1:0]  obs_resp [16];
  logic        obs_last [16];
  int          obs_n = 0;
  int          hs_cyc = 0, first_cyc = 0;
  logic        got_first = 1'b0;

  always @(negedge clk) begin
    chk("arready", 32'(arready), 32'(m_ready));
    chk("rvalid", 32'(rvalid), 32'(m_valid));
    chk("busy", 32'(busy), 32'(!m_idle));
    if (!rst_n) begin
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_rresp", 32'(rresp), 32'd0);
      chk("rst_rlast", 32'(rlast), 32'd0);
    end
    if (m_valid) begin
      chk("rdata", rdata, m_data[m_head]);
      chk("rresp", 32'(rresp), 32'(m_resp[m_head]));
      chk("rlast", 32'(rlast), 32'(m_head == m_n));
    end
    if (arvalid && arready) begin
      hs_cyc = cyc; obs_n = 0; got_first = 1'b0;
    end
    if (rvalid && !got_first) begin
      first_cyc = cyc; got_first = 1'b1;
    end
    if (rvalid && rready && obs_n < 16) begin
      obs_data[obs_n] = rdata; obs_resp[obs_n] = rresp; obs_last[obs_n] = rlast;
      obs_n = obs_n + 1;
    end
  end

  // rready driver, offset from the input-drive point of the main sequence.
  initial begin
    rready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (rr_mode)
        0: rready = 1'b1;
        1: rready = 1'($urandom_range(0, 1));
        default: rready = 1'b0;
      endcase
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic load(input logic [31:0] a, input logic [31:0] d);
    load_we = 1'b1; load_addr = a; load_wdata = d;
    @(posedge clk); #1;
    load_we = 1'b0;
  endtask

  task automatic issue(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                       input logic [1:0] b);
    int g;
    arvalid = 1'b1; araddr = a; arlen = l; arsize = s; arburst = b; arcache = 4'($urandom);
    g = 0;
    @(negedge clk);
    while (!arready && g < 100) begin @(negedge clk); g++; end
    if (!arready) chk("ar_accept_timeout", 32'(arready), 32'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic wait_done();
    int g;
    g = 0;
    @(negedge clk);
    while (!m_idle && g < 2000) begin @(negedge clk); g++; end
    if (!m_idle) chk("burst_end_timeout", 32'(busy), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic run(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                     input logic [1:0] b);
    issue(a, l, s, b);
    wait_done();
  endtask

  task automatic wait_rvalid();
    int g;
    g = 0;
    @(negedge clk);
    while (!rvalid && g < 50) begin @(negedge clk); g++; end
    if (!rvalid) chk("rvalid_timeout", 32'(rvalid), 32'd1);
  endtask

  logic [31:0] load_val [DEPTH];
  logic [31:0] v, a;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; arvalid = 1'b0; araddr = 32'd0; arlen = 8'd0; arsize = 3'd2;
    arburst = 2'b01; arcache = 4'd0; load_we = 1'b0; load_addr = 32'd0; load_wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1 chk("reset_arready", 32'(arready), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("arready_after_release", 32'(arready), 32'd1);

    // image load
    for (int i = 0; i < DEPTH; i++) begin
      v = (i < 4) ? 32'((i + 1) * 32'h11) : $urandom;
      load_val[i] = v;
      load(32'(i * 4), v);
    end

    // single beat, first-beat latency
    run(32'h0, 8'd0, 3'd2, 2'b01);
    chk("t1_latency", 32'(first_cyc - hs_cyc), 32'd2);
    chk("t1_beats", 32'(obs_n), 32'd1);
    chk("t1_data", obs_data[0], 32'h11);
    chk("t1_last", 32'(obs_last[0]), 32'd1);
    chk("t1_resp", 32'(obs_resp[0]), 32'd0);

    // three-beat INCR
    run(32'h4, 8'd2, 3'd2, 2'b01);
    chk("t2_beats", 32'(obs_n), 32'd3);
    chk("t2_d0", obs_data[0], 32'h22);
    chk("t2_d1", obs_data[1], 32'h33);
    chk("t2_d2", obs_data[2], 32'h44);
    chk("t2_l0", 32'(obs_last[0]), 32'd0);
    chk("t2_l1", 32'(obs_last[1]), 32'd0);
    chk("t2_l2", 32'(obs_last[2]), 32'd1);

    // stall for 5 cycles in DATA
    rr_mode = 2;
    issue(32'h8, 8'd0, 3'd2, 2'b01);
    wait_rvalid();
    repeat (5) begin
      @(negedge clk);
      chk("stall_valid", 32'(rvalid), 32'd1);
      chk("stall_data", rdata, 32'h33);
      chk("stall_last", 32'(rlast), 32'd1);
      chk("stall_resp", 32'(rresp), 32'd0);
    end
    @(posedge clk); #1;
    rr_mode = 0;
    wait_done();
    chk("stall_beats", 32'(obs_n), 32'd1);

    // last word then out of range
    run(32'(DEPTH * 4 - 4), 8'd1, 3'd2, 2'b01);
    chk("top_d0", obs_data[0], load_val[DEPTH-1]);
    chk("top_r0", 32'(obs_resp[0]), 32'd0);
    chk("top_d1", obs_data[1], 32'd0);
    chk("top_r1", 32'(obs_resp[1]), 32'd2);
    chk("top_l1", 32'(obs_last[1]), 32'd1);

    // bad size, WRAP, FIXED, 32-bit wrap, unaligned
    run(32'h0, 8'd1, 3'd0, 2'b01);
    chk("size_beats", 32'(obs_n), 32'd2);
    chk("size_r0", 32'(obs_resp[0]), 32'd2);
    chk("size_r1", 32'(obs_resp[1]), 32'd2);
    run(32'h0, 8'd1, 3'd2, 2'b10);
    chk("wrap_r0", 32'(obs_resp[0]), 32'd2);
    chk("wrap_d1", obs_data[1], 32'd0);
    run(32'h8, 8'd3, 3'd2, 2'b00);
    chk("fixed_beats", 32'(obs_n), 32'd4);
    chk("fixed_d0", obs_data[0], 32'h33);
    chk("fixed_d3", obs_data[3], 32'h33);
    chk("fixed_l3", 32'(obs_last[3]), 32'd1);
    run(32'hFFFF_FFFC, 8'd1, 3'd2, 2'b01);
    chk("wrap32_r0", 32'(obs_resp[0]), 32'd2);
    chk("wrap32_d1", obs_data[1], 32'h11);
    chk("wrap32_r1", 32'(obs_resp[1]), 32'd0);
    run(32'h2, 8'd0, 3'd2, 2'b01);
    chk("unal_r0", 32'(obs_resp[0]), 32'd2);

    // load to the word being fetched returns old data, new data afterwards
    issue(32'h10, 8'd0, 3'd2, 2'b01);
    load(32'h10, 32'hDEAD_BEEF);
    wait_done();
    chk("collide_old", obs_data[0], load_val[4]);
    run(32'h10, 8'd0, 3'd2, 2'b01);
    chk("collide_new", obs_data[0], 32'hDEAD_BEEF);
    load_val[4] = 32'hDEAD_BEEF;

    // dropped load writes
    load(32'h11, 32'h1234_5678);
    load(32'(DEPTH * 4), 32'h1234_5678);
    run(32'h10, 8'd0, 3'd2, 2'b01);
    chk("drop_load", obs_data[0], 32'hDEAD_BEEF);

    // reset in the middle of a burst
    rr_mode = 2;
    issue(32'h0, 8'd3, 3'd2, 2'b01);
    wait_rvalid();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rvalid", 32'(rvalid), 32'd0);
    chk("arst_arready", 32'(arready), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_rdata", rdata, 32'd0);
    chk("arst_rlast", 32'(rlast), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; rr_mode = 0;
    @(posedge clk); #1;
    chk("arst_release_arready", 32'(arready), 32'd1);
    repeat (4) begin
      @(negedge clk);
      chk("arst_no_beats", 32'(rvalid), 32'd0);
    end
    @(posedge clk); #1;
    run(32'h0, 8'd3, 3'd2, 2'b01);
    chk("mem_kept0", obs_data[0], 32'h11);
    chk("mem_kept3", obs_data[3], 32'h44);

    // randomized traffic
    rr_mode = 1;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        a = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, DEPTH - 1) * 4);
        load(a, $urandom);
      end
      a = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, DEPTH - 1) * 4);
      run(a, 8'($urandom_range(0, 7)),
          ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'd2,
          ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b01);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/imem_axi_rd_slave.md
IMEM_AXI_RD_SLAVE -- requirements
Module: imem_axi_rd_slave

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, meaning the number of 32-bit words in the instruction memory (power of two).
REQ-002 SHALL have parameter AW, default 10, meaning the word-index width, equal to log2(DEPTH).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port arvalid, input, 1 bit: read address valid from the fetch master.
REQ-006 SHALL have port araddr, input, 32 bits: byte address of the first beat.
REQ-007 SHALL have port arlen, input, 8 bits: beats minus one.
REQ-008 SHALL have port arsize, input, 3 bits: beat size; only 3'd2 (4 bytes) is supported.
REQ-009 SHALL have port arburst, input, 2 bits: burst type, 00 FIXED, 01 INCR, 10 WRAP.
REQ-010 SHALL have port arcache, input, 4 bits: accepted and ignored.
REQ-011 SHALL have port arready, output, 1 bit: address accept.
REQ-012 SHALL have port rvalid, output, 1 bit: read data valid.
REQ-013 SHALL have port rready, input, 1 bit: master data accept.
REQ-014 SHALL have port rdata, output, 32 bits: read word.
REQ-015 SHALL have port rresp, output, 2 bits: 00 OKAY, 10 SLVERR.
REQ-016 SHALL have port rlast, output, 1 bit: final beat of the burst.
REQ-017 SHALL have port load_we, input, 1 bit: image-load write strobe.
REQ-018 SHALL have port load_addr, input, 32 bits: byte address of the image-load word.
REQ-019 SHALL have port load_wdata, input, 32 bits: image-load data.
REQ-020 SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-021 SHALL implement FSM states IDLE, FETCH and DATA.
REQ-022 SHALL drive arready=1 only in IDLE; in IDLE, arvalid&&arready SHALL latch araddr, arlen, arsize and arburst, clear the beat counter and move the FSM to FETCH.
REQ-023 In FETCH the block SHALL perform a one-cycle synchronous read of word araddr[AW+1:2] and then move to DATA.
REQ-024 The first rvalid SHALL assert 2 cycles after the AR handshake cycle.
REQ-025 In DATA the block SHALL hold rvalid=1; while rvalid&&!rready, rdata, rresp and rlast SHALL remain stable.
REQ-026 On rvalid&&rready with rlast=0, the beat counter SHALL increment and the FSM SHALL move to FETCH; the next rvalid follows 2 cycles after that handshake.
REQ-027 On rvalid&&rready with rlast=1, the FSM SHALL move to IDLE and arready SHALL be 1 on the next cycle.
REQ-028 rlast SHALL be 1 exactly when the beat counter equals the latched arlen; arlen=0 gives a single beat with rlast=1.
REQ-029 Address update per beat: INCR adds 4 to the beat address (32-bit wrap at 0xFFFFFFFC to 0); FIXED keeps the address constant.
REQ-030 A beat SHALL return rresp=SLVERR and rdata=0 when any of these holds: arsize!=2, arburst is WRAP or 11, beat address[1:0]!=0, or beat address >= DEPTH*4.
REQ-031 An error SHALL NOT shorten the burst; all arlen+1 beats SHALL be returned.
REQ-032 Otherwise the beat SHALL return rresp=OKAY with rdata equal to mem[addr[AW+1:2]].
REQ-033 load_we SHALL write load_wdata to mem[load_addr[AW+1:2]] in any FSM state; out-of-range or unaligned load writes SHALL be dropped.
REQ-034 When a load write and a FETCH read target the same word in the same cycle, the read SHALL return the old data.
REQ-035 arvalid SHALL be ignored outside IDLE, and no second address SHALL be queued.

Reset
REQ-036 rst_n low SHALL immediately, and asynchronously, force: FSM=IDLE, arready=0, rvalid=0, rlast=0, rresp=00, rdata=0, busy=0, beat counter=0.
REQ-037 On the first clock edge after rst_n is released, arready SHALL be 1.
REQ-038 Reset mid-burst SHALL abort the burst with no further beats.
REQ-039 Memory contents SHALL NOT be cleared by reset.

Verification
REQ-040 Bench: load mem[0..3]=0x11,0x22,0x33,0x44, then AR araddr=0, arlen=0, INCR, rready=1 -> rvalid 2 cycles after the handshake with rdata=0x11, rlast=1, rresp=00.
REQ-041 Bench: araddr=0x4, arlen=2, INCR -> beats 0x22, 0x33, 0x44 with rlast only on the third beat, and arready=1 the cycle after that beat.
REQ-042 Bench: rready held 0 for 5 cycles in DATA -> rvalid stays 1 with rdata, rlast and rresp unchanged; the beat completes when rready=1.
REQ-043 Bench: araddr=DEPTH*4-4, arlen=1, INCR -> beat 0 OKAY with data, beat 1 SLVERR with rdata=0 and rlast=1.
REQ-044 Bench: arsize=0 or arburst=10, arlen=1 -> two SLVERR beats; FIXED burst at 0x8 with arlen=3 -> four beats of 0x33.
REQ-045 Bench: rst_n pulsed low during DATA of an arlen=3 burst -> rvalid=0 at once, no further beats, arready=1 the first edge after release, memory contents intact.
